// File: rtl/gost_block_core.sv
// Iterative GOST 28147-89 / Magma 64-bit block engine (ECB encrypt/decrypt) with valid/ready
// handshakes on both sides; ROUNDS_PER_CYCLE unrolled Feistel rounds per clock.

module replacer #(
  parameter int unsigned R_WIDTH = 32
) (
  input  logic [R_WIDTH-1:0] data_i,
  output logic [R_WIDTH-1:0] data_o
);

  // Row n holds Pi'n with entry v in bits [4v+3:4v]; nibble i of the word uses row i%8.
  function automatic logic [63:0] sbox_row(input logic [2:0] idx);
    case (idx)
      3'd0:    return 64'h1F30_7D8E_9B5A_264C;
      3'd1:    return 64'hF0DB_74E1_C5A9_3286;
      3'd2:    return 64'h069C_471E_DAF2_853B;
      3'd3:    return 64'hB9E3_5A07_6F4D_128C;
      3'd4:    return 64'hC24B_E390_D618_A5F7;
      3'd5:    return 64'h0E34_187B_AC29_6FD5;
      3'd6:    return 64'h73AD_0B4F_C196_52E8;
      default: return 64'h2BC9_6AF4_3850_DE71;
    endcase
  endfunction

  logic [63:0] row;

  always_comb begin
    data_o = '0;
    row    = '0;
    for (int unsigned i = 0; i < R_WIDTH / 4; i++) begin
      row              = sbox_row(3'(i % 8));
      data_o[4*i +: 4] = row[{data_i[4*i +: 4], 2'b00} +: 4];
    end
  end

endmodule

module gost_block_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [255:0] key_i,
  input  logic         decrypt_i,
  input  logic [63:0]  data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [63:0]  data_o,
  output logic         valid_o,
  input  logic         ready_i
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [31:0]    n1_q, n2_q;
  logic [255:0]   key_q;
  logic           dec_q;
  logic [4:0]     rnd_q;
  logic [63:0]    data_q;
  logic           ready_q, valid_q;

  logic [31:0]    n1_c [R+1];
  logic [31:0]    n2_c [R+1];
  logic [31:0]    n1_d, n2_d;
  logic           last_c;

  // Encrypt: K0..K7 three times then K7..K0; decrypt: K0..K7 once then K7..K0 three times.
  // 7-x on a 3-bit index is just ~x.
  function automatic logic [2:0] key_idx(input logic [4:0] r, input logic dec);
    if (!dec) return (r < 5'd24) ? r[2:0] : ~r[2:0];
    else      return (r < 5'd8)  ? r[2:0] : ~r[2:0];
  endfunction

  function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] j);
    return k[{~j, 5'b0} +: 32];
  endfunction

  assign n1_c[0] = n1_q;
  assign n2_c[0] = n2_q;

  for (genvar u = 0; u < R; u++) begin : g_round
    logic [31:0] rk, sum, sub;

    assign rk  = key_word(key_q, key_idx(rnd_q + 5'(u), dec_q));
    assign sum = n1_c[u] + rk;

    replacer #(.R_WIDTH(32)) u_replacer (
      .data_i(sum),
      .data_o(sub)
    );

    assign n1_c[u+1] = n2_c[u] ^ {sub[20:0], sub[31:21]};
    assign n2_c[u+1] = n1_c[u];
  end

  assign n1_d   = n1_c[R];
  assign n2_d   = n2_c[R];
  assign last_c = (rnd_q == 5'(32 - R));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      n1_q    <= '0;
      n2_q    <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      rnd_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            n1_q    <= data_i[31:0];
            n2_q    <= data_i[63:32];
            key_q   <= key_i;
            dec_q   <= decrypt_i;
            rnd_q   <= '0;
            ready_q <= 1'b0;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          n1_q  <= n1_d;
          n2_q  <= n2_d;
          rnd_q <= rnd_q + 5'(R);
          // Emitting {N1,N2} rather than {N2,N1} cancels the swap of the final round.
          if (last_c) begin
            data_q  <= {n1_d, n2_d};
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_gost_block_core.sv
// Scoreboard bench: three engines (1, 2 and 4 rounds per clock) share one stimulus stream;
// expected block and first-valid cycle are queued on send and checked when valid_o rises.

module tb_gost_block_core;

  localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;
  localparam int           LAT [3] = '{32, 16, 8};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key;
  logic         dec;
  logic [63:0]  din;
  logic         vin;
  logic         rdy_in;
  logic         rdy  [3];
  logic [63:0]  dout [3];
  logic         vout [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gost_block_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .key_i    (key),
      .decrypt_i(dec),
      .data_i   (din),
      .valid_i  (vin),
      .ready_o  (rdy[g]),
      .data_o   (dout[g]),
      .valid_o  (vout[g]),
      .ready_i  (rdy_in)
    );
  end

  typedef struct {
    int          dut;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic vprev [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: on each rising valid_o, match the oldest entry for that engine.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && vout[k] && !vprev[k]) begin
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].dut == k) idx = i;
        if (idx < 0) begin
          check_val($sformatf("spurious_valid_r%0d", 1 << k), 64'(vout[k]), 64'(0));
        end else begin
          check_val($sformatf("data_r%0d", 1 << k), dout[k], sb[idx].data);
          check_val($sformatf("latency_r%0d", 1 << k), 64'(cyc), 64'(sb[idx].due));
          sb.delete(idx);
        end
      end
      vprev[k] = vout[k];
    end
  end

  task automatic send(input logic [255:0] k, input logic [63:0] d, input logic dc,
                      input logic [63:0] exp);
    for (int c = 0; c < 100 && !(rdy[0] && rdy[1] && rdy[2]); c++) @(negedge clk);
    check_val("ready_before_send", 64'(rdy[0] && rdy[1] && rdy[2]), 64'(1));
    key = k;
    din = d;
    dec = dc;
    vin = 1'b1;
    for (int g = 0; g < 3; g++) sb.push_back('{dut: g, data: exp, due: cyc + 1 + LAT[g]});
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
    check_val(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    key    = '0;
    dec    = 1'b0;
    din    = '0;
    vin    = 1'b0;
    rdy_in = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("reset_ready_r%0d", 1 << k), 64'(rdy[k]), 64'(1));
      check_val($sformatf("reset_valid_r%0d", 1 << k), 64'(vout[k]), 64'(0));
      check_val($sformatf("reset_data_r%0d", 1 << k), dout[k], 64'(0));
    end
    rst_n = 1'b1;

    // Encrypt / decrypt reference vectors, accepted on the first edge after reset release.
    send(KEY, PT, 1'b0, CT);
    drain("drain_enc");
    send(KEY, CT, 1'b1, PT);
    drain("drain_dec");

    // Inputs scrambled every cycle while the engines are busy.
    send(KEY, PT, 1'b0, CT);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      din = {$urandom, $urandom};
      dec = 1'($urandom);
      @(negedge clk);
    end
    check_val("drain_scramble", 64'(sb.size()), 64'(0));

    // Output backpressure: DONE held with valid_i pulses that must be ignored.
    rdy_in = 1'b0;
    send(KEY, PT, 1'b0, CT);
    for (int c = 0; c < 100 && !(vout[0] && vout[1] && vout[2]); c++) @(negedge clk);
    check_val("bp_all_valid", 64'(vout[0] && vout[1] && vout[2]), 64'(1));
    for (int c = 0; c < 10; c++) begin
      vin = 1'($urandom);
      din = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_val($sformatf("bp_valid_r%0d", 1 << k), 64'(vout[k]), 64'(1));
        check_val($sformatf("bp_data_r%0d", 1 << k), dout[k], CT);
        check_val($sformatf("bp_ready_r%0d", 1 << k), 64'(rdy[k]), 64'(0));
      end
    end
    vin    = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("release_ready_r%0d", 1 << k), 64'(rdy[k]), 64'(1));
      check_val($sformatf("release_valid_r%0d", 1 << k), 64'(vout[k]), 64'(0));
      check_val($sformatf("retain_data_r%0d", 1 << k), dout[k], CT);
    end
    check_val("bp_queue_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset while the single-round engine is in round 13.
    send(KEY, PT, 1'b0, CT);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("abort_ready_r%0d", 1 << k), 64'(rdy[k]), 64'(1));
      check_val($sformatf("abort_valid_r%0d", 1 << k), 64'(vout[k]), 64'(0));
      check_val($sformatf("abort_data_r%0d", 1 << k), dout[k], 64'(0));
    end
    sb.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    send(KEY, PT, 1'b0, CT);
    drain("drain_after_reset");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
